vending_controller: RTL

VENDING_CONTROLLER -- requirements
Module: vending_controller

---
 rtl/vending_pkg.sv | 14 +
 rtl/coin_decoder.sv | 29 ++
 rtl/vending_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: FSM state encoding and coin values.
package vending_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    REFUND  = 2'd2
  } state_t;

  localparam logic [2:0] COIN_ONE  = 3'd1;
  localparam logic [2:0] COIN_TWO  = 3'd2;
  localparam logic [2:0] COIN_FIVE = 3'd5;

endpackage

// File: rtl/coin_decoder.sv
// Combinational coin decoder: exactly one coin line high is a valid coin.
// Several lines high at once is an invalid coin; no line high is neither.
module coin_decoder
  import vending_pkg::*;
(
  input  logic       one,
  input  logic       two,
  input  logic       five,
  output logic       valid,
  output logic       invalid,
  output logic [2:0] value
);

  // Map the one-hot coin lines to a value; anything else is idle or invalid.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid   = 1'b0;
    invalid = 1'b0;
    value   = 3'd0;
    case ({five, two, one})
      3'b000: ;
      3'b001: begin valid = 1'b1; value = COIN_ONE;  end
      3'b010: begin valid = 1'b1; value = COIN_TWO;  end
      3'b100: begin valid = 1'b1; value = COIN_FIVE; end
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/vending_controller.sv
// Vending controller: accumulates coins, dispenses with change once the price
// is reached, refunds on cancel, and locks out coins for a fixed time after.
module vending_controller
  import vending_pkg::*;
#(
  parameter int PRICE       = 5,
  parameter int CREDIT_W    = 4,
  parameter int VEND_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                one,
  input  logic                two,
  input  logic                five,
  input  logic                cancel,
  output logic                d,
  output logic [CREDIT_W-1:0] r,
  output logic                rf,
  output logic                rej,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // Sums are kept one bit wider than credit so comparisons never wrap.
  localparam logic [CREDIT_W:0] PRICE_X   = (CREDIT_W + 1)'(PRICE);
  // Lockout counter is loaded so that busy stays high for exactly VEND_CYCLES cycles.
  localparam logic [3:0]        LOCK_INIT = 4'(VEND_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [CREDIT_W-1:0] credit_d, r_d;
  logic                d_d, rf_d, rej_d, busy_d;

  logic                coin_valid, coin_invalid;
  logic [2:0]          coin_value;
  logic [CREDIT_W:0]   sum;

  coin_decoder u_coin_decoder (
    .one     (one),
    .two     (two),
    .five    (five),
    .valid   (coin_valid),
    .invalid (coin_invalid),
    .value   (coin_value)
  );

  // Credit plus the coin being offered this cycle (zero if none or invalid).
  assign sum = {1'b0, credit} +
               (coin_valid ? {{(CREDIT_W - 2){1'b0}}, coin_value} : '0);

  // Next-state and next-output logic; every output pulse is a default-zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    credit_d = credit;
    r_d      = '0;
    d_d      = 1'b0;
    rf_d     = 1'b0;
    rej_d    = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      COLLECT: begin
        rej_d = coin_invalid;
        if (cancel) begin
          // Cancel takes priority over a vend triggered by the same coin.
          if (sum != '0) begin
            rf_d     = 1'b1;
            r_d      = sum[CREDIT_W-1:0];
            credit_d = '0;
            state_d  = REFUND;
            cnt_d    = LOCK_INIT;
            busy_d   = 1'b1;
          end
        end else if (coin_valid) begin
          if (sum < PRICE_X) begin
            credit_d = sum[CREDIT_W-1:0];
          end else begin
            d_d      = 1'b1;
            r_d      = CREDIT_W'(sum - PRICE_X);
            credit_d = '0;
            state_d  = VEND;
            cnt_d    = LOCK_INIT;
            busy_d   = 1'b1;
          end
        end
      end
      VEND, REFUND: begin
        // During lockout every coin is bounced and cancel has no effect.
        rej_d  = one | two | five;
        busy_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = COLLECT;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State, counter, credit and all outputs registered; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= COLLECT;
      cnt_q   <= 4'd0;
      credit  <= '0;
      r       <= '0;
      d       <= 1'b0;
      rf      <= 1'b0;
      rej     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      credit  <= credit_d;
      r       <= r_d;
      d       <= d_d;
      rf      <= rf_d;
      rej     <= rej_d;
      busy    <= busy_d;
    end
  end

endmodule
